ap_ctrl_txn_profiler: RTL and testbench
=======================================

// Module: ap_ctrl_txn_profiler
// PURPOSE
//  Synthesizable downstream consumer of one HLS block-level handshake (ap_start/ap_ready/ap_done/ap_continue).
//  Timestamps each accepted transaction, pairs it with its completion, emits one record per transaction
//  (latency, start-to-start interval, txn id) through a valid/ready stream into a record FIFO.
//  Sits beside the DUT, fed by the same handshake nets the module-status monitor samples; on-chip status equivalent.
// PARAMETERS
//  CNT_W     32  width of free-running cycle counter, latency and interval fields
//  ID_W      16  transaction id width (wraps)
//  MAX_OUTST  4  timestamp queue depth = max in-flight transactions (power of 2)
//  REC_DEPTH  8  record FIFO depth (power of 2)
// PORTS
//  clock        in   1      single clock, all logic rising-edge
//  reset        in   1      asynchronous, active-low reset
//  ap_start     in   1      observed DUT start
//  ap_ready     in   1      observed DUT ready
//  ap_done      in   1      observed DUT done
//  ap_continue  in   1      observed DUT continue (tie 1 for ap_ctrl_hs)
//  finish       in   1      end of run; stop accepting, drain in-flight
//  rec_valid    out  1      record available
//  rec_ready    in   1      consumer accepts record
//  rec_data     out  rec_t  {id, latency, interval[, stall]}
//  drained      out  1      FSM in DONE
//  err_flags    out  3      sticky {orphan_done, ts_overflow, rec_drop}
//  drop_cnt     out  16     saturating count of dropped records
// BEHAVIOUR
//  Reset: all outputs 0, counter 0, queues empty, FSM IDLE, next id 0.
//  accept = ap_start&ap_ready; complete = ap_done&ap_continue; sampled each rising edge.
//  cyc counter increments every cycle, wraps mod 2^CNT_W; latency = cyc_done - ts (mod 2^CNT_W).
//  FSM: IDLE -accept-> RUN; RUN -finish-> DRAIN; DRAIN -queue empty & no pending record-> DONE;
//   IDLE -finish-> DONE; DONE holds until reset. accepts ignored in DRAIN/DONE; completes still paired in DRAIN.
//  accept: push cyc into timestamp queue; interval = cyc - prev_accept (0 for first after reset); id++.
//  complete: pop oldest ts, build record, write record FIFO next cycle (record latency 1 cycle after complete).
//  Same-cycle accept+complete, queue non-empty: pop-then-push, both applied. Queue empty: latency 0 record.
//  complete with empty queue and no accept: set orphan_done, no record.
//  accept with queue full (and no same-cycle pop): set ts_overflow, transaction not tracked, id still increments.
//  Record FIFO full on write (no same-cycle read): set rec_drop, drop_cnt++ (saturate 16'hFFFF), record lost.
//  Output stream: rec_data stable while rec_valid & !rec_ready; transfer when both high; FIFO is first-word fall-through.
//  Simultaneous FIFO read and write when full: both succeed, no drop.
//  Reset asserted mid-operation: immediate clear of all state, in-flight records discarded.
// CONFIGURATION
//  AP_PROF_STALL_EN defined: each record carries stall field (CNT_W) = cycles with ap_done&!ap_continue
//   before the complete; counter clears on complete. Undefined: field absent, rec_t narrower, no stall logic.
// STRUCTURE
//  Package ap_prof_pkg: rec_t packed struct, prof_state_e enum {IDLE,RUN,DRAIN,DONE}, err bit index localparams.
//  Sub-module ap_prof_fifo (parametric width/depth, FWFT, full/empty) instantiated for timestamp queue and record FIFO.
// TESTING
//  3 back-to-back accepts at cyc 2,5,9, each done 10 cycles later, rec_ready=1 -> records id0..2, latency 10,
//   interval 0,3,4.
//  5 accepts with no done (MAX_OUTST=4) -> ts_overflow=1 on 5th; 4 later completes give 4 records, ids 0..3.
//  rec_ready=0, 10 completes (REC_DEPTH=8) -> drop_cnt=2, rec_drop=1; then drain 8 records in order.
//  ap_done=1 with no prior accept -> orphan_done=1, rec_valid stays 0.
//  2 in flight, finish=1, later 1 accept, 2 completes -> accept ignored, 2 records, drained=1 after last write.
//  STALL_EN: ap_done held 4 cycles with ap_continue=0 then 1 -> record stall=4; reset mid-run -> all outputs 0.

Source files
------------

// File: rtl/ap_prof_pkg.sv
// Shared types for the HLS block-level handshake transaction profiler.
//   rec_t        : record emitted per transaction {id, latency, interval[, stall]}
//   ts_entry_t   : in-flight transaction held in the timestamp queue
//   prof_state_e : run-control FSM states
// Optional feature macro: AP_PROF_STALL_EN adds the stall field to rec_t.
package ap_prof_pkg;

  localparam int unsigned CNT_W = 32;  // cycle counter / latency / interval width
  localparam int unsigned ID_W  = 16;  // transaction id width, wraps

  // Bit positions inside err_flags.
  localparam int unsigned ErrDropIdx     = 0;
  localparam int unsigned ErrOverflowIdx = 1;
  localparam int unsigned ErrOrphanIdx   = 2;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} prof_state_e;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] latency;
    logic [CNT_W-1:0] interval;
`ifdef AP_PROF_STALL_EN
    logic [CNT_W-1:0] stall;
`endif
  } rec_t;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] ts;
    logic [CNT_W-1:0] interval;
  } ts_entry_t;

endpackage

// File: rtl/ap_ctrl_txn_profiler_if.sv
// Handshake and record-stream bundle for ap_ctrl_txn_profiler.
//   ap_start/ap_ready/ap_done/ap_continue : observed HLS block-level handshake
//   rec_valid/rec_ready/rec_data          : record output stream
// master: the environment (drives handshake and rec_ready)
// slave : the profiler (observes handshake, drives the record stream)
interface ap_ctrl_txn_profiler_if;
  import ap_prof_pkg::*;

  logic ap_start;
  logic ap_ready;
  logic ap_done;
  logic ap_continue;
  logic rec_valid;
  logic rec_ready;
  rec_t rec_data;

  modport master (
    output ap_start, ap_ready, ap_done, ap_continue, rec_ready,
    input  rec_valid, rec_data
  );

  modport slave (
    input  ap_start, ap_ready, ap_done, ap_continue, rec_ready,
    output rec_valid, rec_data
  );

endinterface

// File: rtl/ap_prof_fifo.sv
// First-word fall-through FIFO used for the timestamp queue and the record FIFO.
//   clock, reset (async active-low)
//   wr_en/wr_data : write; accepted when not full, or when full with a same-cycle read
//   rd_en/rd_data : read; rd_data shows the head whenever not empty
//   full, empty   : occupancy flags
// Depth must be a power of two, at least 2.
module ap_prof_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  output logic [Width-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wptr_q, rptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_wr, do_rd;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + PtrOne;
      if (do_rd) rptr_q <= rptr_q + PtrOne;
    end
  end

  // Storage needs no reset: it is only visible through the pointers.
  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ap_ctrl_txn_profiler.sv
// Transaction profiler for one HLS ap_ctrl handshake. Timestamps each accepted start,
// pairs it in order with its completion and emits one record per transaction.
//   clock, reset (async active-low)
//   bus       : slave modport; observed handshake in, record stream out
//   finish    : stop accepting new transactions, drain those in flight
//   drained   : FSM has reached DONE
//   err_flags : sticky {orphan_done, ts_overflow, rec_drop}
//   drop_cnt  : saturating count of records lost to a full record FIFO
// Optional feature macro: AP_PROF_STALL_EN adds a per-record count of cycles spent
// with ap_done high and ap_continue low before the completion.
module ap_ctrl_txn_profiler
  import ap_prof_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned REC_DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  ap_ctrl_txn_profiler_if.slave  bus,
  input  logic                   finish,
  output logic                   drained,
  output logic [2:0]             err_flags,
  output logic [15:0]            drop_cnt
);

  prof_state_e      state_q, state_d;
  logic [CNT_W-1:0] cyc_q, prev_acc_q;
  logic             have_prev_q;
  logic [ID_W-1:0]  id_q;
  logic [2:0]       err_q, err_d;
  logic [15:0]      drop_cnt_q;
  rec_t             pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;

  logic             accept, complete, acc_en;
  logic [CNT_W-1:0] interval;
  logic             ts_push, ts_pop, ts_full, ts_empty, bypass;
  logic             overflow, orphan, drop;
  ts_entry_t        ts_new, ts_head;
  rec_t             rec_out;
  logic             rec_full, rec_empty, rec_valid, rec_rd;

  assign accept   = bus.ap_start & bus.ap_ready;
  assign complete = bus.ap_done & bus.ap_continue;
  // An accept coinciding with finish in IDLE is dropped: the run ends before it starts.
  assign acc_en   = accept & ((state_q == StRun) | ((state_q == StIdle) & ~finish));
  assign interval = have_prev_q ? (cyc_q - prev_acc_q) : '0;

  // Completion with nothing queued pairs directly with a same-cycle accept.
  assign ts_pop   = complete & ~ts_empty;
  assign bypass   = complete & ts_empty & acc_en;
  assign ts_push  = acc_en & ~bypass;
  assign overflow = ts_push & ts_full & ~ts_pop;
  assign orphan   = complete & ts_empty & ~acc_en;
  assign ts_new   = '{id: id_q, ts: cyc_q, interval: interval};

  ap_prof_fifo #(
    .Width ($bits(ts_entry_t)),
    .Depth (MAX_OUTST)
  ) u_ts_queue (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (ts_push),
    .wr_data (ts_new),
    .rd_en   (ts_pop),
    .rd_data (ts_head),
    .full    (ts_full),
    .empty   (ts_empty)
  );

`ifdef AP_PROF_STALL_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (complete) begin
      stall_q <= '0;
    end else if (bus.ap_done & ~bus.ap_continue) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end
`endif

  // Record built at the completion edge, written to the record FIFO one cycle later.
  always_comb begin
    pend_d       = pend_q;
    pend_valid_d = ts_pop | bypass;
    if (ts_pop) begin
      pend_d.id       = ts_head.id;
      pend_d.latency  = cyc_q - ts_head.ts;
      pend_d.interval = ts_head.interval;
    end else begin
      pend_d.id       = id_q;
      pend_d.latency  = '0;
      pend_d.interval = interval;
    end
`ifdef AP_PROF_STALL_EN
    pend_d.stall = stall_q;
`endif
  end

  assign rec_rd = rec_valid & bus.rec_ready;
  assign drop   = pend_valid_q & rec_full & ~rec_rd;

  ap_prof_fifo #(
    .Width ($bits(rec_t)),
    .Depth (REC_DEPTH)
  ) u_rec_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (pend_valid_q),
    .wr_data (pend_q),
    .rd_en   (rec_rd),
    .rd_data (rec_out),
    .full    (rec_full),
    .empty   (rec_empty)
  );

  assign rec_valid     = ~rec_empty;
  assign bus.rec_valid = rec_valid;
  // Gate the unreset FIFO storage so the stream reads zero when idle.
  assign bus.rec_data  = rec_valid ? rec_out : '0;

  always_comb begin
    err_d               = err_q;
    err_d[ErrOrphanIdx]   = err_q[ErrOrphanIdx] | orphan;
    err_d[ErrOverflowIdx] = err_q[ErrOverflowIdx] | overflow;
    err_d[ErrDropIdx]     = err_q[ErrDropIdx] | drop;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (finish) begin
          state_d = StDone;
        end else if (accept) begin
          state_d = StRun;
        end
      end
      StRun:   if (finish) state_d = StDrain;
      StDrain: if (ts_empty && !pend_valid_q) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cyc_q        <= '0;
      prev_acc_q   <= '0;
      have_prev_q  <= 1'b0;
      id_q         <= '0;
      err_q        <= '0;
      drop_cnt_q   <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_q + CNT_W'(1);
      err_q        <= err_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      // Overflowed accepts still count: they advance the id and the interval base.
      if (acc_en) begin
        prev_acc_q  <= cyc_q;
        have_prev_q <= 1'b1;
        id_q        <= id_q + ID_W'(1);
      end
      if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drained   = (state_q == StDone);
  assign err_flags = err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_ap_ctrl_txn_profiler.sv
// Self-checking bench for ap_ctrl_txn_profiler: directed scenarios followed by a random
// phase, all checked every cycle against a transaction-level reference model.
// Build with AP_PROF_STALL_EN defined to exercise the stall field.
module tb_ap_ctrl_txn_profiler;
  import ap_prof_pkg::*;

  localparam int unsigned MaxOutst = 4;
  localparam int unsigned RecDepth = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        finish = 1'b0;
  logic        drained;
  logic [2:0]  err_flags;
  logic [15:0] drop_cnt;

  always #5 clock = ~clock;

  ap_ctrl_txn_profiler_if bus ();

  ap_ctrl_txn_profiler #(
    .MAX_OUTST (MaxOutst),
    .REC_DEPTH (RecDepth)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .finish    (finish),
    .drained   (drained),
    .err_flags (err_flags),
    .drop_cnt  (drop_cnt)
  );

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    int unsigned ts;
    int unsigned id;
    int unsigned ivl;
  } txn_t;

  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned m_cyc, m_prev, m_drop, m_stall;
  bit          m_have_prev;
  logic [15:0] m_id;
  txn_t        m_tsq[$];
  rec_t        m_fifo[$];
  rec_t        m_pend;
  bit          m_pend_v;
  bit [2:0]    m_err;   // {orphan, overflow, drop}
  int          m_phase; // 0 idle, 1 run, 2 drain, 3 done
  rec_t        got[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_prev = 0; m_drop = 0; m_stall = 0; m_have_prev = 0; m_id = '0;
    m_tsq.delete(); m_fifo.delete(); m_pend = '0; m_pend_v = 0; m_err = '0; m_phase = 0;
  endtask

  // Apply the rules of one rising edge to the model, using the inputs now on the pins.
  task automatic model_edge();
    bit          acc, cmp, acc_en, rd, wr_ok, q_empty0, pend0, used;
    int unsigned ivl;
    txn_t        t;
    rec_t        r;
    acc      = bus.ap_start && bus.ap_ready;
    cmp      = bus.ap_done && bus.ap_continue;
    q_empty0 = (m_tsq.size() == 0);
    pend0    = m_pend_v;
    rd       = (m_fifo.size() != 0) && bus.rec_ready;
    wr_ok    = m_pend_v && ((m_fifo.size() < RecDepth) || rd);
    if (m_pend_v && !wr_ok) begin
      m_err[0] = 1'b1;
      if (m_drop < 16'hFFFF) m_drop++;
    end
    if (rd) void'(m_fifo.pop_front());
    if (wr_ok) m_fifo.push_back(m_pend);
    m_pend_v = 0;
    acc_en = acc && (m_phase == 1 || (m_phase == 0 && !finish));
    ivl    = m_have_prev ? (m_cyc - m_prev) : 0;
    used   = 0;
    r      = '0;
    if (cmp) begin
      if (m_tsq.size() != 0) begin
        t = m_tsq.pop_front();
        r.id = t.id[15:0]; r.latency = m_cyc - t.ts; r.interval = t.ivl;
        m_pend_v = 1;
      end else if (acc_en) begin
        r.id = m_id; r.latency = 0; r.interval = ivl;
        m_pend_v = 1; used = 1;
      end else begin
        m_err[2] = 1'b1;
      end
    end
`ifdef AP_PROF_STALL_EN
    r.stall = m_stall;
    if (cmp) m_stall = 0;
    else if (bus.ap_done && !bus.ap_continue) m_stall++;
`endif
    if (m_pend_v) m_pend = r;
    if (acc_en) begin
      if (!used) begin
        if (m_tsq.size() < MaxOutst) m_tsq.push_back('{ts: m_cyc, id: int'(m_id), ivl: ivl});
        else m_err[1] = 1'b1;
      end
      m_prev = m_cyc; m_have_prev = 1; m_id = m_id + 16'd1;
    end
    case (m_phase)
      0: if (finish) m_phase = 3; else if (acc) m_phase = 1;
      1: if (finish) m_phase = 2;
      2: if (q_empty0 && !pend0) m_phase = 3;
      default: ;
    endcase
    m_cyc++;
  endtask

  // One clock: compare outputs (settled since last edge), advance model, cross the edge.
  task automatic step();
    check("rec_valid", 128'(bus.rec_valid), 128'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) check("rec_data", 128'(bus.rec_data), 128'(m_fifo[0]));
    check("err_flags", 128'(err_flags), 128'(m_err));
    check("drop_cnt", 128'(drop_cnt), 128'(m_drop));
    check("drained", 128'(drained), 128'(m_phase == 3));
    if (bus.rec_valid && bus.rec_ready) got.push_back(bus.rec_data);
    model_edge();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input bit s, input bit r, input bit d, input bit c, input bit rr,
                       input bit f);
    bus.ap_start = s; bus.ap_ready = r; bus.ap_done = d; bus.ap_continue = c;
    bus.rec_ready = rr; finish = f;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_rec_valid", 128'(bus.rec_valid), 128'(0));
    check("rst_rec_data", 128'(bus.rec_data), 128'(0));
    check("rst_err_flags", 128'(err_flags), 128'(0));
    check("rst_drop_cnt", 128'(drop_cnt), 128'(0));
    check("rst_drained", 128'(drained), 128'(0));
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    got.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  int unsigned ivl_tab[3] = '{0, 3, 4};

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clock);

    // Three accepts at cycles 2, 5, 9, each done 10 cycles later.
    do_reset();
    for (int c = 0; c < 26; c++) begin
      drive(c == 2 || c == 5 || c == 9, 1, c == 12 || c == 15 || c == 19, 1, 1, 0);
      step();
    end
    check("s1_count", 128'(got.size()), 128'(3));
    if (got.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("s1_id", 128'(got[i].id), 128'(i));
        check("s1_latency", 128'(got[i].latency), 128'(10));
        check("s1_interval", 128'(got[i].interval), 128'(ivl_tab[i]));
      end
    end

    // Five accepts with no done: fifth overflows, four completes give ids 0..3.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drive(c >= 1 && c <= 5, 1, c >= 10 && c <= 13, 1, 1, 0);
      step();
    end
    check("s2_overflow", 128'(err_flags[1]), 128'(1));
    check("s2_count", 128'(got.size()), 128'(4));
    if (got.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("s2_id", 128'(got[i].id), 128'(i));
        check("s2_latency", 128'(got[i].latency), 128'(9));
      end
    end

    // Ten same-cycle accept+complete with rec_ready low: two records dropped.
    do_reset();
    for (int c = 0; c < 14; c++) begin
      drive(c < 10, c < 10, c < 10, 1, 0, 0);
      step();
    end
    check("s3_drop_cnt", 128'(drop_cnt), 128'(2));
    check("s3_rec_drop", 128'(err_flags[0]), 128'(1));
    for (int c = 0; c < 12; c++) begin
      drive(0, 0, 0, 1, 1, 0);
      step();
    end
    check("s3_count", 128'(got.size()), 128'(8));
    if (got.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("s3_id", 128'(got[i].id), 128'(i));
        check("s3_latency", 128'(got[i].latency), 128'(0));
      end
    end

    // Done with nothing accepted: orphan, no record.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(0, 1, c == 1, 1, 1, 0);
      step();
    end
    check("s4_err", 128'(err_flags), 128'(3'b100));
    check("s4_rec_valid", 128'(bus.rec_valid), 128'(0));
    check("s4_count", 128'(got.size()), 128'(0));

    // Two in flight, finish, a late accept ignored, two completes, then drained.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      drive(c == 1 || c == 2 || c == 6, 1, c == 8 || c == 9, 1, 1, c >= 4);
      step();
    end
    check("s5_count", 128'(got.size()), 128'(2));
    check("s5_drained", 128'(drained), 128'(1));
    check("s5_err", 128'(err_flags), 128'(0));
    if (got.size() == 2) check("s5_last_id", 128'(got[1].id), 128'(1));

`ifdef AP_PROF_STALL_EN
    // Done held four cycles with continue low before completing.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      drive(c == 1, 1, c >= 3 && c <= 7, c == 7, 1, 0);
      step();
    end
    check("s6_count", 128'(got.size()), 128'(1));
    if (got.size() == 1) begin
      check("s6_stall", 128'(got[0].stall), 128'(4));
      check("s6_latency", 128'(got[0].latency), 128'(6));
    end
`endif

    // Random traffic, finish near the end.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(99) < 50, $urandom_range(99) < 70, $urandom_range(99) < 40,
            $urandom_range(99) < 80, $urandom_range(99) < 60, c >= 520);
      step();
    end

    // Reset while records are waiting in the FIFO.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(1, 1, 1, 1, 0, 0);
      step();
    end
    check("s7_pre_valid", 128'(bus.rec_valid), 128'(1));
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 1, 1, 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
